// File: rtl/apb_mem_slave.sv
// APB completer in front of a registered 1-cycle-latency memory, with programmable wait states.
// Latency: setup + WAIT_STATES access cycles (ready=0), then one DONE cycle with ready=1.
// Backpressure: ready is held low while the access counter runs; dropping sel during ACCESS aborts.
// Optional feature macro: APB_RDONLY_REGION_EN (writes below RO_LIMIT answer slverr, memory untouched).
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 200,
  parameter int WAIT_STATES = 2,
  parameter int RO_LIMIT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sel_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  slverr_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [DATA_WIDTH-1:0] data_in_o,
  input  logic [DATA_WIDTH-1:0] data_out_i
);

  // Counter only needs to hold WAIT_STATES; keep at least one bit so an
  // illegal configuration still elaborates far enough to hit the $error.
  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_mem_slave: WAIT_STATES must be in 1..15");
  end
  if (MEM_DEPTH < 1 || RO_LIMIT < 0) begin : g_bad_range
    $error("apb_mem_slave: MEM_DEPTH must be >= 1 and RO_LIMIT >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;     // latched address out of range
  logic                  ro_q, ro_d;       // latched write into read-only region
  logic                  capture;
  logic                  addr_oor;
  logic                  addr_ro;

  // Range decode of the incoming setup address; registered at capture so the
  // response never depends on addr_i after the setup phase.
  always_comb begin
    addr_oor = (32'(addr_i) >= 32'(MEM_DEPTH));
`ifdef APB_RDONLY_REGION_EN
    addr_ro  = write_i && !addr_oor && (32'(addr_i) < 32'(RO_LIMIT));
`else
    addr_ro  = 1'b0;
`endif
  end

  // Next-state logic: setup capture from IDLE or DONE, countdown in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    ro_d    = ro_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        // enable without a preceding setup phase is not a transfer
        capture = sel_i && !enable_i;
      end
      S_ACCESS: begin
        if (!sel_i) begin
          state_d = S_IDLE;
        end else if (enable_i) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_DONE: begin
        // a setup coincident with completion starts the next transfer directly
        capture = sel_i && !enable_i;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      state_d = S_ACCESS;
      cnt_d   = CNT_LOAD;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      write_d = write_i;
      err_d   = addr_oor;
      ro_d    = addr_ro;
    end
  end

  // State and latched-transfer registers; reset drops any pending write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      ro_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      ro_q    <= ro_d;
    end
  end

  // Responses exist only in DONE; memory data is already valid on entry.
  always_comb begin
    ready_o   = (state_q == S_DONE);
    slverr_o  = ready_o && (err_q || ro_q);
    wr_o      = ready_o && write_q && !err_q && !ro_q;
    rdata_o   = (ready_o && !write_q && !err_q) ? data_out_i : '0;
    address_o = addr_q;
    data_in_o = wdata_q;
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomised APB traffic against apb_mem_slave with a transaction-level reference model.
// Expected responses are scheduled per cycle from setup time + WAIT_STATES + 1.
// A per-cycle compare process checks every output cycle; directed literals pin the model.
module tb_apb_mem_slave;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int WS    = 2;
  localparam int ROL   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          en  = 1'b0;
  logic          wrt = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, slverr, wr;
  logic [DW-1:0] rdata, data_in;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out = '0;

  apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .WAIT_STATES(WS), .RO_LIMIT(ROL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .enable_i(en), .write_i(wrt),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .slverr_o(slverr),
    .rdata_o(rdata), .wr_o(wr), .address_o(address), .data_in_o(data_in),
    .data_out_i(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the DUT: registered read, write on the wr strobe.
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  always @(posedge clk) begin
    if (wr) mem[address] <= data_in;
    data_out <= mem[address];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  typedef struct packed {
    logic          slverr;
    logic [DW-1:0] rdata;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t expq [int];
  bit   run_cmp = 1'b0;

  // Reference: what one completed transfer must return, updating the shadow memory.
  function automatic exp_t model(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   ai  = int'(a);
    bit   oor = (ai >= DEPTH);
    bit   ro  = 1'b0;
`ifdef APB_RDONLY_REGION_EN
    ro = w && !oor && (ai < ROL);
`endif
    e.slverr = oor || ro;
    e.wr     = w && !e.slverr;
    e.rdata  = (!w && !oor) ? shadow[ai] : '0;
    e.a      = a;
    e.d      = d;
    if (e.wr) shadow[ai] = d;
    return e;
  endfunction

  // Every sampled cycle: either the scheduled response, or all-quiet outputs.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (run_cmp) begin
      if (expq.exists(cyc)) begin
        e = expq[cyc];
        chk("ready", 32'(ready), 32'd1);
        chk("slverr", 32'(slverr), 32'(e.slverr));
        chk("rdata", rdata, e.rdata);
        chk("wr", 32'(wr), 32'(e.wr));
        if (e.wr) begin
          chk("wr_address", 32'(address), 32'(e.a));
          chk("wr_data", data_in, e.d);
        end
        expq.delete(cyc);
      end else begin
        chk("idle_ready", 32'(ready), 32'd0);
        chk("idle_slverr", 32'(slverr), 32'd0);
        chk("idle_rdata", rdata, 32'd0);
        chk("idle_wr", 32'(wr), 32'd0);
      end
    end
  end

  // Drive one transfer starting now; returns in the DONE cycle (or the cycle after an abort).
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int abort_at, input bit noise,
                      output int setup_cyc, output int done_cyc);
    setup_cyc = cyc;
    done_cyc  = -1;
    sel = 1'b1; en = 1'b0; wrt = w; addr = a; wdata = d;
    @(posedge clk); #1;
    for (int k = 0; k < WS; k++) begin
      if (k == abort_at) begin
        sel = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        return;
      end
      en = 1'b1;
      if (noise) begin
        wrt = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
      end
      @(posedge clk); #1;
    end
    sel = 1'b0; en = 1'b0;
    expq[cyc] = model(w, a, d);
    done_cyc  = cyc;
  endtask

  // Idle cycles, sometimes with a stray enable that must not start a transfer.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = 1'b1; en = 1'b1;
      end else begin
        sel = 1'b0; en = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    sel = 1'b0; en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int s, d, s2, d2, ab, gap;
    logic [AW-1:0] ra;
    bit rw;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'hA5A50000 | 32'(i);
      shadow[i] = 32'hA5A50000 | 32'(i);
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_slverr", 32'(slverr), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_wr", 32'(wr), 32'd0);
    chk("reset_address", 32'(address), 32'd0);
    chk("reset_data_in", data_in, 32'd0);
    rst = 1'b0;
    run_cmp = 1'b1;
    @(posedge clk); #1;

    // write then read back 0x20; DONE is cycle 4 counting the setup cycle as 1
    xfer(1'b1, 8'h20, 32'hDEADBEEF, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t2_latency", 32'(d - s + 1), 32'd4);
    chk("t2_wr", 32'(wr), 32'd1);
    chk("t2_slverr", 32'(slverr), 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 8'h20, 32'h0, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // out-of-range read and write
    xfer(1'b0, 8'hF0, 32'h0, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t3_rd_slverr", 32'(slverr), 32'd1);
    chk("t3_rd_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    xfer(1'b1, 8'hF0, 32'h55AA55AA, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t3_wr_slverr", 32'(slverr), 32'd1);
    chk("t3_wr_strobe", 32'(wr), 32'd0);
    @(posedge clk); #1;

    // back-to-back: second setup in the first DONE cycle; its DONE is 3 edges later
    xfer(1'b1, 8'h40, 32'h11112222, -1, 1'b0, s, d);
    xfer(1'b0, 8'h40, 32'h0, -1, 1'b0, s2, d2);
    @(negedge clk); #1;
    chk("t4_no_gap", 32'(s2), 32'(d));
    chk("t4_spacing", 32'(d2 - d), 32'd3);
    chk("t4_rdata", rdata, 32'h11112222);
    @(posedge clk); #1;

    // abort on the 2nd access cycle; the old value must survive
    xfer(1'b1, 8'h05, 32'hCAFEF00D, 1, 1'b0, s, d);
    chk("t5_aborted", 32'(d), 32'hFFFFFFFF);
    xfer(1'b0, 8'h05, 32'h0, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t5_old_value", rdata, 32'hA5A50005);
    @(posedge clk); #1;

    // reset during the 2nd access cycle of a write
    sel = 1'b1; en = 1'b0; wrt = 1'b1; addr = 8'h30; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t1_ready", 32'(ready), 32'd0);
    chk("t1_wr", 32'(wr), 32'd0);
    chk("t1_address", 32'(address), 32'd0);
    chk("t1_data_in", data_in, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 8'h30, 32'h0, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t1_mem_untouched", rdata, 32'hA5A50030);
    @(posedge clk); #1;

    // read-only region below RO_LIMIT
    xfer(1'b1, 8'h0A, 32'h00001234, -1, 1'b0, s, d);
    @(negedge clk); #1;
`ifdef APB_RDONLY_REGION_EN
    chk("t6_ro_slverr", 32'(slverr), 32'd1);
    chk("t6_ro_wr", 32'(wr), 32'd0);
`else
    chk("t6_ro_slverr", 32'(slverr), 32'd0);
    chk("t6_ro_wr", 32'(wr), 32'd1);
`endif
    @(posedge clk); #1;
    xfer(1'b1, 8'h10, 32'h00001234, -1, 1'b0, s, d);
    @(negedge clk); #1;
    chk("t6_rw_slverr", 32'(slverr), 32'd0);
    chk("t6_rw_wr", 32'(wr), 32'd1);
    @(posedge clk); #1;

    // randomized traffic: mixed ranges, aborts, gaps, back-to-back and bus noise
    for (int n = 0; n < 400; n++) begin
      rw = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       ra = AW'($urandom_range(DEPTH, 255));
        1, 2:    ra = AW'($urandom_range(0, ROL + 3));
        3, 4, 5: ra = AW'($urandom_range(0, 31));
        default: ra = AW'($urandom_range(0, DEPTH - 1));
      endcase
      ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, WS - 1)) : -1;
      xfer(rw, ra, $urandom, ab, 1'($urandom), s, d);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end

    idle(3);
    run_cmp = 1'b0;
    chk("pending_responses", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
